ifetch_ctrl32: RTL and testbench

Instruction-fetch stage of the 32-bit MIPS-subset CPU, directly upstream of `Executs32`. It owns the program counter and fetches one instruction word per request/acknowledge handshake with instruction memory. It presents the instruction and `PC_plus_4` to decode/execute. When the downstream stage retires the instruction, it takes the branch/jump resolution that execute and decode feed back (`Add_Result`, `Zero`, `Read_data_1`, control flags) and selects the next PC.

---
 rtl/cpu32_pkg.sv | 16 +
 rtl/next_pc_sel32.sv | 35 +++
 rtl/ifetch_ctrl32.sv | 103 ++++++++++
 tb/tb_ifetch_ctrl32.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu32_pkg.sv
// rtl/cpu32_pkg.sv - shared types and constants for the 32-bit MIPS-subset CPU
package cpu32_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        VALID = 1'b1
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

endpackage

// File: rtl/next_pc_sel32.sv
// rtl/next_pc_sel32.sv - priority mux selecting the word-aligned next program counter
module next_pc_sel32 (
    input  logic [31:0] pc_plus_4,
    input  logic [25:0] jump_index,
    input  logic [31:0] add_result,
    input  logic        zero,
    input  logic [31:0] read_data_1,
    input  logic        branch,
    input  logic        nbranch,
    input  logic        jmp,
    input  logic        jal,
    input  logic        jrn,
    output logic [31:0] next_pc
);

    logic [31:0] target;
    logic        branch_hit;

    assign branch_hit = (branch & zero) | (nbranch & ~zero);

    always_comb begin
        target = pc_plus_4;
        if (jrn) begin
            target = read_data_1;
        end else if (jmp || jal) begin
            target = {pc_plus_4[31:28], jump_index, 2'b00};
        end else if (branch_hit) begin
            target = add_result;
        end
    end

    // Misaligned register/branch targets are silently truncated to a word boundary.
    assign next_pc = target & 32'hFFFF_FFFC;

endmodule

// File: rtl/ifetch_ctrl32.sv
// rtl/ifetch_ctrl32.sv - instruction fetch stage: PC, fetch handshake and next-PC update
module ifetch_ctrl32
    import cpu32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic        inst_valid,
    input  logic        inst_taken,
    output logic [31:0] PC_plus_4,
    output logic [31:0] opcplus4,
    input  logic [31:0] Add_Result,
    input  logic        Zero,
    input  logic [31:0] Read_data_1,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jrn
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic [31:0]  inst_count;
    logic         capture;
    logic         retire;

    assign capture   = (state == FETCH) && imem_ack;
    assign retire    = (state == VALID) && inst_taken;
    assign imem_addr = pc;
    assign PC_plus_4 = pc + 32'd4;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (imem_ack)   state_next = VALID;
            VALID:   if (inst_taken) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Handshake outputs come only from the state register so no input reaches them combinationally.
    always_comb begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        case (state)
            FETCH:   imem_req   = 1'b1;
            VALID:   inst_valid = 1'b1;
            default: imem_req   = 1'b0;
        endcase
    end

    next_pc_sel32 u_next_pc_sel (
        .pc_plus_4   (PC_plus_4),
        .jump_index  (Instruction[25:0]),
        .add_result  (Add_Result),
        .zero        (Zero),
        .read_data_1 (Read_data_1),
        .branch      (Branch),
        .nbranch     (nBranch),
        .jmp         (Jmp),
        .jal         (Jal),
        .jrn         (Jrn),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            Instruction <= 32'h0000_0000;
            opcplus4    <= 32'h0000_0000;
            inst_count  <= 32'h0000_0000;
        end else begin
            if (capture) begin
                Instruction <= imem_rdata;
            end
            if (retire) begin
                pc         <= next_pc;
                inst_count <= inst_count + 32'd1;
                if (Jal) begin
                    opcplus4 <= PC_plus_4;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl32.sv
// tb/tb_ifetch_ctrl32.sv - directed self-checking bench for ifetch_ctrl32
module tb_ifetch_ctrl32;
    import cpu32_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] Instruction;
    logic        inst_valid;
    logic        inst_taken = 1'b0;
    logic [31:0] PC_plus_4;
    logic [31:0] opcplus4;
    logic [31:0] Add_Result = 32'h0;
    logic        Zero = 1'b0;
    logic [31:0] Read_data_1 = 32'h0;
    logic        Branch = 1'b0;
    logic        nBranch = 1'b0;
    logic        Jmp = 1'b0;
    logic        Jal = 1'b0;
    logic        Jrn = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_count = 32'h0;

    always #5 clock = ~clock;

    ifetch_ctrl32 #(.RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Instruction (Instruction),
        .inst_valid  (inst_valid),
        .inst_taken  (inst_taken),
        .PC_plus_4   (PC_plus_4),
        .opcplus4    (opcplus4),
        .Add_Result  (Add_Result),
        .Zero        (Zero),
        .Read_data_1 (Read_data_1),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jrn         (Jrn)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch_word(input logic [31:0] w);
        imem_ack   = 1'b1;
        imem_rdata = w;
        step();
        imem_ack   = 1'b0;
    endtask

    task automatic retire(input logic jrn, input logic jmp, input logic jal,
                          input logic br, input logic nbr, input logic z,
                          input logic [31:0] add, input logic [31:0] rd1);
        Jrn = jrn; Jmp = jmp; Jal = jal; Branch = br; nBranch = nbr; Zero = z;
        Add_Result = add; Read_data_1 = rd1;
        inst_taken = 1'b1;
        step();
        inst_taken = 1'b0;
        Jrn = 0; Jmp = 0; Jal = 0; Branch = 0; nBranch = 0; Zero = 0;
        Add_Result = 32'h0; Read_data_1 = 32'h0;
        exp_count = exp_count + 32'd1;
    endtask

    task automatic jump_to(input logic [31:0] a);
        fetch_word(32'h0000_0008);
        retire(1, 0, 0, 0, 0, 0, 32'h0, a);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req got %b want 1", imem_req); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", inst_valid); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 00000000", imem_addr); end
        n_cmp++; if (PC_plus_4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc4 got %h want 00000004", PC_plus_4); end
        n_cmp++; if (Instruction !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h want 00000000", Instruction); end
        n_cmp++; if (opcplus4 !== 32'h0) begin n_fail++; $display("FAIL reset_opc got %h want 00000000", opcplus4); end
        n_cmp++; if (dut.inst_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got %h want 00000000", dut.inst_count); end
    endtask

    task automatic test_fetch();
        step();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL fetch_hold req=%b addr=%h want 1 00000000", imem_req, imem_addr); end
        step();
        fetch_word(32'h2001_0005);
        n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid got %b want 1", inst_valid); end
        n_cmp++; if (Instruction !== 32'h2001_0005) begin n_fail++; $display("FAIL fetch_inst got %h want 20010005", Instruction); end
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_req_low got %b want 0", imem_req); end
        // ack while VALID must not overwrite the held instruction
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        n_cmp++; if (Instruction !== 32'h2001_0005 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL ack_in_valid inst=%h valid=%b want 20010005 1", Instruction, inst_valid); end
        retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        n_cmp++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL seq_addr got %h want 00000004", imem_addr); end
        n_cmp++; if (dut.inst_count !== 32'd1) begin n_fail++; $display("FAIL seq_count got %0d want 1", dut.inst_count); end
    endtask

    task automatic test_branch();
        fetch_word({OP_BEQ, 26'h0000009});
        retire(0, 0, 0, 1, 0, 1, 32'h28, 32'h0);
        n_cmp++; if (imem_addr !== 32'h28) begin n_fail++; $display("FAIL beq_taken got %h want 00000028", imem_addr); end
        jump_to(32'h4);
        fetch_word({OP_BEQ, 26'h0000009});
        retire(0, 0, 0, 1, 0, 0, 32'h28, 32'h0);
        n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL beq_not_taken got %h want 00000008", imem_addr); end
        jump_to(32'h4);
        fetch_word({OP_BNE, 26'h0000009});
        retire(0, 0, 0, 0, 1, 0, 32'h28, 32'h0);
        n_cmp++; if (imem_addr !== 32'h28) begin n_fail++; $display("FAIL bne_taken got %h want 00000028", imem_addr); end
    endtask

    task automatic test_jal();
        jump_to(32'h14);
        fetch_word(32'h0C00_0010);
        retire(0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        n_cmp++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL jal_addr got %h want 00000040", imem_addr); end
        n_cmp++; if (opcplus4 !== 32'h18) begin n_fail++; $display("FAIL jal_link got %h want 00000018", opcplus4); end
    endtask

    task automatic test_priority_align();
        fetch_word({OP_J, 26'h0000005});
        retire(1, 1, 0, 1, 0, 1, 32'h0000_0100, 32'h0000_0033);
        n_cmp++; if (imem_addr !== 32'h30) begin n_fail++; $display("FAIL jr_prio_addr got %h want 00000030", imem_addr); end
        n_cmp++; if (opcplus4 !== 32'h18) begin n_fail++; $display("FAIL jr_opc_hold got %h want 00000018", opcplus4); end
    endtask

    task automatic test_back_to_back();
        // ack in the very first FETCH cycle after the retire
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        n_cmp++; if (inst_valid !== 1'b1 || Instruction !== 32'h1234_5678) begin n_fail++; $display("FAIL same_cycle_ack valid=%b inst=%h want 1 12345678", inst_valid, Instruction); end
        retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        n_cmp++; if (imem_addr !== 32'h34) begin n_fail++; $display("FAIL b2b_addr got %h want 00000034", imem_addr); end
        Jrn = 1'b1; Read_data_1 = 32'h0000_0100; inst_taken = 1'b1;
        step();
        inst_taken = 1'b0; Jrn = 1'b0; Read_data_1 = 32'h0;
        n_cmp++; if (imem_addr !== 32'h34 || imem_req !== 1'b1) begin n_fail++; $display("FAIL taken_in_fetch addr=%h req=%b want 00000034 1", imem_addr, imem_req); end
        n_cmp++; if (dut.inst_count !== exp_count) begin n_fail++; $display("FAIL taken_in_fetch_count got %0d want %0d", dut.inst_count, exp_count); end
    endtask

    task automatic test_wrap();
        jump_to(32'hFFFF_FFFF);
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC || PC_plus_4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc addr=%h pc4=%h want fffffffc 00000000", imem_addr, PC_plus_4); end
        fetch_word(32'h0);
        retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next got %h want 00000000", imem_addr); end
        n_cmp++; if (dut.inst_count !== exp_count) begin n_fail++; $display("FAIL wrap_count got %0d want %0d", dut.inst_count, exp_count); end
    endtask

    task automatic test_reset_during_fetch();
        jump_to(32'h40);
        n_cmp++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin n_fail++; $display("FAIL pre_reset addr=%h req=%b want 00000040 1", imem_addr, imem_req); end
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
        step();
        reset = 1'b0; imem_ack = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ack_valid got %b want 0", inst_valid); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_ack_addr got %h want 00000000", imem_addr); end
        n_cmp++; if (Instruction !== 32'h0) begin n_fail++; $display("FAIL rst_ack_inst got %h want 00000000", Instruction); end
        n_cmp++; if (dut.inst_count !== 32'h0) begin n_fail++; $display("FAIL rst_ack_count got %0d want 0", dut.inst_count); end
        n_cmp++; if (opcplus4 !== 32'h0) begin n_fail++; $display("FAIL rst_ack_opc got %h want 00000000", opcplus4); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_branch();
        test_jal();
        test_priority_align();
        test_back_to_back();
        test_wrap();
        test_reset_during_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
